pipe_ctrl_unit: RTL

Second-generation control unit for the pipelined RISC-V core. It decodes the ID-stage opcode and carries the control bits through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards (stall plus bubble) and taken-branch flushes, and honours a global hold from the memory system. Its outputs drive the datapath mux selects, the PC/IF-ID write enables and the IF/ID flush.

---
 rtl/pipe_ctrl_pkg.sv | 44 ++++
 rtl/pipe_ctrl_unit_ctrl_decode.sv | 70 +++++++
 rtl/pipe_ctrl_unit.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipelined control unit.
// Holds the opcode, ALUOp and select encodings, the control bundle carried down the pipe,
// and the per-stage register payload (control bundle plus destination register).
package pipe_ctrl_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned CNT_W   = 16;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_BR  = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_R   = 2'b10;

  localparam logic SRC_REG = 1'b0;
  localparam logic SRC_IMM = 1'b1;
  localparam logic WB_ALU  = 1'b0;
  localparam logic WB_MEM  = 1'b1;

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // One pipeline register: control bits and the rd that travels with them.
  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rd;
  } stage_t;

endpackage

// File: rtl/pipe_ctrl_unit_ctrl_decode.sv
// ID-stage opcode decoder (purely combinational).
// Ports: valid_i/op_i in; ctrl_o (control bundle), rs1_used_o, rs2_used_o,
// known_o (opcode belongs to a supported class and valid_i is set) out.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic            valid_i,
  input  logic [OP_W-1:0] op_i,
  output ctrl_t           ctrl_o,
  output logic            rs1_used_o,
  output logic            rs2_used_o,
  output logic            known_o
);

  // Unknown opcodes and empty slots fall through to the all-zero bubble.
  always_comb begin
    ctrl_o     = CTRL_BUBBLE;
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    known_o    = 1'b0;
    if (valid_i) begin
      case (op_i)
        OP_R: begin
          ctrl_o.alu_op    = ALUOP_R;
          ctrl_o.alu_src   = SRC_REG;
          ctrl_o.reg_write = 1'b1;
          rs1_used_o       = 1'b1;
          rs2_used_o       = 1'b1;
          known_o          = 1'b1;
        end
        OP_I: begin
          ctrl_o.alu_op    = ALUOP_ADD;
          ctrl_o.alu_src   = SRC_IMM;
          ctrl_o.reg_write = 1'b1;
          rs1_used_o       = 1'b1;
          known_o          = 1'b1;
        end
        OP_LOAD: begin
          ctrl_o.alu_op     = ALUOP_ADD;
          ctrl_o.alu_src    = SRC_IMM;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.mem_to_reg = WB_MEM;
          ctrl_o.reg_write  = 1'b1;
          rs1_used_o        = 1'b1;
          known_o           = 1'b1;
        end
        OP_STORE: begin
          ctrl_o.alu_op    = ALUOP_ADD;
          ctrl_o.alu_src   = SRC_IMM;
          ctrl_o.mem_write = 1'b1;
          rs1_used_o       = 1'b1;
          rs2_used_o       = 1'b1;
          known_o          = 1'b1;
        end
        OP_BRANCH: begin
          ctrl_o.alu_op  = ALUOP_BR;
          ctrl_o.alu_src = SRC_REG;
          ctrl_o.branch  = 1'b1;
          rs1_used_o     = 1'b1;
          rs2_used_o     = 1'b1;
          known_o        = 1'b1;
        end
        default: begin
          ctrl_o.mem_to_reg = WB_ALU;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes the ID opcode, carries control through ID/EX, EX/MEM
// and MEM/WB, detects load-use hazards and taken-branch flushes, and honours hold_i.
// Ports: clk_i, rst_i (sync, active-low); ID inputs valid_i/op_i/rs1_i/rs2_i/rd_i;
// branch_taken_i, hold_i; stall_o/flush_o (combinational); ex_*, mem_*, wb_* stage controls.
// Optional macro PIPE_CTRL_PERF_EN adds saturating stall_cnt_o / flush_cnt_o counters.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [OP_W-1:0]    op_i,
  input  logic [REG_AW-1:0]  rs1_i,
  input  logic [REG_AW-1:0]  rs2_i,
  input  logic [REG_AW-1:0]  rd_i,
  input  logic               branch_taken_i,
  input  logic               hold_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic [ALUOP_W-1:0] ex_alu_op_o,
  output logic               ex_alu_src_o,
  output logic               ex_branch_o,
  output logic [REG_AW-1:0]  ex_rd_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [REG_AW-1:0]  mem_rd_o,
  output logic               wb_reg_write_o,
  output logic               wb_mem_to_reg_o,
  output logic [REG_AW-1:0]  wb_rd_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
`endif
);

  ctrl_t  dec_ctrl;
  logic   rs1_used, rs2_used, dec_known;
  stage_t id_ex_q, ex_mem_q, mem_wb_q;
  stage_t id_ex_d;
  logic   load_use, flush, stall;

  ctrl_decode u_decode (
    .valid_i    (valid_i),
    .op_i       (op_i),
    .ctrl_o     (dec_ctrl),
    .rs1_used_o (rs1_used),
    .rs2_used_o (rs2_used),
    .known_o    (dec_known)
  );

  // Hazard detection; a taken branch wins over load-use, hold masks the flush.
  always_comb begin
    load_use = 1'b0;
    flush    = 1'b0;
    stall    = 1'b0;
    id_ex_d  = '0;
    load_use = id_ex_q.ctrl.mem_read && (id_ex_q.rd != '0) &&
               ((rs1_used && (rs1_i == id_ex_q.rd)) ||
                (rs2_used && (rs2_i == id_ex_q.rd)));
    flush    = id_ex_q.ctrl.branch && branch_taken_i && !hold_i;
    stall    = hold_i || (load_use && !flush);
    if (dec_known && !flush && !load_use) begin
      id_ex_d.ctrl = dec_ctrl;
      id_ex_d.rd   = rd_i;
    end
  end

  // Pipeline registers: frozen under hold, bubble injected into ID/EX on hazard.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else if (!hold_i) begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= id_ex_q;
      mem_wb_q <= ex_mem_q;
    end
  end

  assign stall_o         = stall;
  assign flush_o         = flush;
  assign ex_alu_op_o     = id_ex_q.ctrl.alu_op;
  assign ex_alu_src_o    = id_ex_q.ctrl.alu_src;
  assign ex_branch_o     = id_ex_q.ctrl.branch;
  assign ex_rd_o         = id_ex_q.rd;
  assign mem_read_o      = ex_mem_q.ctrl.mem_read;
  assign mem_write_o     = ex_mem_q.ctrl.mem_write;
  assign mem_rd_o        = ex_mem_q.rd;
  assign wb_reg_write_o  = mem_wb_q.ctrl.reg_write;
  assign wb_mem_to_reg_o = mem_wb_q.ctrl.mem_to_reg;
  assign wb_rd_o         = mem_wb_q.rd;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters; hold cycles are excluded.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!hold_i && load_use && !flush && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule
